bcp_implication_arbiter: RTL and testbench
==========================================

# bcp_implication_arbiter

Sequential arbiter that sits directly downstream of the eight BCP clause-evaluator lanes and upstream of the trail/assignment writer. It captures implied literals from unit clauses as they are detected, holds them in per-lane pending slots, and issues them one at a time in fixed priority order: highest lane index first, using the same 8-to-3 priority rule as the combinational encoder. Output uses a valid/ready handshake, and a flush input discards all pending work on backtrack.

## Interface
Parameters:
- LIT_W, 16, width of an encoded literal (variable index plus sign bit in the LSB)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_in  in  8  per-lane new-implication strobe, one cycle per implication
- lit_in  in  8*LIT_W  per-lane literal; lane i occupies bits [i*LIT_W +: LIT_W]; sampled only when req_in[i]=1
- flush  in  1  synchronous discard of all pending and presented implications
- impl_valid  out  1  implication presented
- impl_ready  in  1  downstream accepts
- impl_lane  out  3  source lane of the presented implication
- impl_lit  out  LIT_W  presented literal
- pending_cnt  out  4  population count of the pending vector (0..8)
- idle  out  1  high when no pending bits and impl_valid=0
- overflow  out  1  sticky lane-overwrite flag; present only with BCP_ARB_OVERFLOW_EN, otherwise tied 0

## Operation
- State: pend[7:0], lit_q[8][LIT_W], output register (impl_valid, impl_lane, impl_lit), overflow.
- Reset (rst_n=0, asynchronous): pend=0, lit_q=0, impl_valid=0, impl_lane=0, impl_lit=0, overflow=0. As a result, pending_cnt=0 and idle=1.
- Capture: when req_in[i]=1, lit_q[i] is set to lit_in lane i and pend[i] is set to 1.
- Selection: sel is the highest index i with pend[i]=1. Selection applies only when pend≠0.
- Load condition: load = (|pend) && (!impl_valid || impl_ready) && !flush.
  - On load: impl_valid←1, impl_lane←sel, impl_lit←lit_q[sel], pend[sel]←0.
- Drain: impl_valid && impl_ready && !load gives impl_valid←0.
- Next-state equation: pend_next = (pend & ~(load ? onehot(sel) : 0)) | req_in.
  - A req_in on the lane being loaded in the same cycle leaves pend[sel]=1 with the new literal.
  - The loaded output takes the old lit_q value, because the read happens before the write.
- Re-request on a lane already pending and not being loaded: the literal is overwritten by the newer one, and only one implication is issued. With the macro enabled, overflow is set.
- Flush: pend←0 and impl_valid←0. Flush has priority over req_in and over load in the same cycle, so requests arriving in the flush cycle are dropped. lit_q, impl_lane and impl_lit keep their values. overflow is not cleared by flush.
- Output stability: while impl_valid=1 and impl_ready=0, impl_lane and impl_lit hold, even if a higher-priority lane becomes pending.
- pending_cnt and idle are combinational from the registered state.

## Timing
- Latency, empty arbiter:
  - req_in at cycle N gives pend visible at N+1.
  - impl_valid=1 with that literal at N+2.
- Throughput: one implication per cycle while impl_ready=1 and pend≠0. Back-to-back loads happen on consecutive cycles.
- Ordering is by lane priority, not arrival time. A lower lane waits while higher lanes keep re-requesting (no fairness guarantee).
- flush at cycle N: impl_valid=0 and pending_cnt=0 from N+1.
- Reset deasserted mid-operation: the arbiter restarts empty, and no implication is issued until a new req_in.

## Configuration
- BCP_ARB_OVERFLOW_EN defined:
  - overflow is set the cycle after req_in[i]=1 coincides with pend[i]=1 and lane i is not being loaded (and flush=0).
  - It stays set until rst_n.
- BCP_ARB_OVERFLOW_EN undefined:
  - overflow is constant 0 and no detection logic is built.
  - Overwrite behaviour of lit_q is identical in both builds.

## Test plan
- Reset, then no requests: impl_valid=0, pending_cnt=0, idle=1, overflow=0 across 10 cycles.
- Single request: req_in=8'h04 with lane2 lit=16'h0013, impl_ready=1 → impl_valid=1 at N+2, impl_lane=2, impl_lit=16'h0013 for one cycle, then idle=1.
- Priority drain: req_in=8'hA5 in one cycle, impl_ready=1 → lanes issued 7,5,2,0 on four consecutive cycles; pending_cnt reads 4,3,2,1,0.
- Backpressure: impl_ready=0 with lane1 presented, then req_in=8'h80 → impl_lane stays 1 until the ready cycle; lane7 is issued on the next cycle.
- Flush collision: pend=8'h0F, impl_valid=1, and flush=1 together with req_in=8'h10 → next cycle impl_valid=0, pending_cnt=0; lane4 is never issued.
- Overwrite (macro on): lane3 pending with lit A and not selected, then req lane3 with lit B → exactly one lane3 issue carrying B; overflow=1 from the next cycle. Same sequence with the macro off → overflow=0.

Source files
------------

// File: rtl/bcp_implication_arbiter.sv
// bcp_implication_arbiter
// Collects implied literals from the eight BCP clause-evaluator lanes.
// Each lane has one pending slot. Pending implications are issued one at a
// time, highest lane index first, through a valid/ready output register.
// A flush discards all pending work and the presented implication.
// Optional feature: define BCP_ARB_OVERFLOW_EN to build a sticky flag that
// records when a lane is re-requested while its slot is still pending.
module bcp_implication_arbiter #(
    parameter int LIT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         req_in,
    input  logic [8*LIT_W-1:0] lit_in,
    input  logic               flush,
    output logic               impl_valid,
    input  logic               impl_ready,
    output logic [2:0]         impl_lane,
    output logic [LIT_W-1:0]   impl_lit,
    output logic [3:0]         pending_cnt,
    output logic               idle,
    output logic               overflow
);

    logic [7:0]       pend;
    logic [LIT_W-1:0] lit_q [8];
    logic [2:0]       sel;
    logic [7:0]       load_mask;
    logic             load;
    logic [3:0]       cnt;

    // Pick the highest pending lane; later iterations override earlier ones
    always_comb begin
        sel = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pend[i]) sel = 3'(i);
        end
    end

    // Load when work is pending, the output slot is free or being taken, and no flush
    always_comb begin
        load      = (|pend) && (!impl_valid || impl_ready) && !flush;
        load_mask = load ? (8'b1 << sel) : 8'b0;
    end

    // Population count of the pending vector
    always_comb begin
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, pend[i]};
        end
    end

    assign pending_cnt = cnt;
    assign idle        = (pend == 8'b0) && !impl_valid;

    // Pending bits: clear the loaded lane, then set newly requested lanes; flush wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 8'b0;
        end else if (flush) begin
            pend <= 8'b0;
        end else begin
            pend <= (pend & ~load_mask) | req_in;
        end
    end

    // Per-lane literal slots; a newer request overwrites an older pending literal
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) lit_q[i] <= '0;
        end else if (!flush) begin
            for (int i = 0; i < 8; i++) begin
                if (req_in[i]) lit_q[i] <= lit_in[i*LIT_W +: LIT_W];
            end
        end
    end

    // Output register: holds while stalled, reads the slot before this cycle's write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            impl_valid <= 1'b0;
            impl_lane  <= 3'd0;
            impl_lit   <= '0;
        end else if (flush) begin
            impl_valid <= 1'b0;
        end else if (load) begin
            impl_valid <= 1'b1;
            impl_lane  <= sel;
            impl_lit   <= lit_q[sel];
        end else if (impl_ready) begin
            impl_valid <= 1'b0;
        end
    end

`ifdef BCP_ARB_OVERFLOW_EN
    // Sticky flag: a request hit a lane that is pending and not leaving this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (!flush && |(req_in & pend & ~load_mask)) begin
            overflow <= 1'b1;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_bcp_implication_arbiter.sv
// Directed testbench for bcp_implication_arbiter.
// Inputs are driven 1 time unit after each rising edge, and outputs are
// checked at that same point. Every expected value is written by hand.
module tb_bcp_implication_arbiter;

    localparam int LIT_W = 16;

    logic               clk;
    logic               rst_n;
    logic [7:0]         req_in;
    logic [8*LIT_W-1:0] lit_in;
    logic               flush;
    logic               impl_valid;
    logic               impl_ready;
    logic [2:0]         impl_lane;
    logic [LIT_W-1:0]   impl_lit;
    logic [3:0]         pending_cnt;
    logic               idle;
    logic               overflow;

    int  checks;
    int  failures;
    logic exp_ovf;

    bcp_implication_arbiter #(.LIT_W(LIT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_in      (req_in),
        .lit_in      (lit_in),
        .flush       (flush),
        .impl_valid  (impl_valid),
        .impl_ready  (impl_ready),
        .impl_lane   (impl_lane),
        .impl_lit    (impl_lit),
        .pending_cnt (pending_cnt),
        .idle        (idle),
        .overflow    (overflow)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if it does not match
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Put one lane's literal on the packed input bus
    task automatic setLit(input int lane, input logic [LIT_W-1:0] v);
        lit_in[lane*LIT_W +: LIT_W] = v;
    endtask

    // Drive the control inputs, then advance to 1 unit past the next rising edge
    task automatic applyStimulus(input logic [7:0] req, input logic ready, input logic fl);
        req_in     = req;
        impl_ready = ready;
        flush      = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
`ifdef BCP_ARB_OVERFLOW_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        rst_n      = 1'b0;
        req_in     = 8'h00;
        lit_in     = '0;
        flush      = 1'b0;
        impl_ready = 1'b0;
        #12;
        checkOutput("rst_valid", {31'b0, impl_valid}, 32'd0);
        checkOutput("rst_cnt", {28'b0, pending_cnt}, 32'd0);
        checkOutput("rst_idle", {31'b0, idle}, 32'd1);
        checkOutput("rst_lit", {16'b0, impl_lit}, 32'd0);
        rst_n = 1'b1;

        // Quiet after reset
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'h00, 1'b1, 1'b0);
            checkOutput("quiet_valid", {31'b0, impl_valid}, 32'd0);
            checkOutput("quiet_idle", {31'b0, idle}, 32'd1);
            checkOutput("quiet_ovf", {31'b0, overflow}, 32'd0);
        end

        // Single request on lane 2
        setLit(2, 16'h0013);
        applyStimulus(8'h04, 1'b1, 1'b0);
        checkOutput("single_n1_valid", {31'b0, impl_valid}, 32'd0);
        checkOutput("single_n1_cnt", {28'b0, pending_cnt}, 32'd1);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("single_n2_valid", {31'b0, impl_valid}, 32'd1);
        checkOutput("single_n2_lane", {29'b0, impl_lane}, 32'd2);
        checkOutput("single_n2_lit", {16'b0, impl_lit}, 32'h0013);
        checkOutput("single_n2_cnt", {28'b0, pending_cnt}, 32'd0);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("single_n3_valid", {31'b0, impl_valid}, 32'd0);
        checkOutput("single_n3_idle", {31'b0, idle}, 32'd1);

        // Priority drain of 8'hA5: lanes 7,5,2,0
        for (int i = 0; i < 8; i++) setLit(i, 16'h0100 + 16'(i));
        applyStimulus(8'hA5, 1'b1, 1'b0);
        checkOutput("drain_cnt0", {28'b0, pending_cnt}, 32'd4);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("drain_lane7", {29'b0, impl_lane}, 32'd7);
        checkOutput("drain_lit7", {16'b0, impl_lit}, 32'h0107);
        checkOutput("drain_cnt1", {28'b0, pending_cnt}, 32'd3);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("drain_lane5", {29'b0, impl_lane}, 32'd5);
        checkOutput("drain_cnt2", {28'b0, pending_cnt}, 32'd2);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("drain_lane2", {29'b0, impl_lane}, 32'd2);
        checkOutput("drain_cnt3", {28'b0, pending_cnt}, 32'd1);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("drain_lane0", {29'b0, impl_lane}, 32'd0);
        checkOutput("drain_lit0", {16'b0, impl_lit}, 32'h0100);
        checkOutput("drain_valid0", {31'b0, impl_valid}, 32'd1);
        checkOutput("drain_cnt4", {28'b0, pending_cnt}, 32'd0);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("drain_end_idle", {31'b0, idle}, 32'd1);

        // Backpressure: lane 1 held while lane 7 arrives
        setLit(1, 16'h0201);
        setLit(7, 16'h0207);
        applyStimulus(8'h02, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("bp_lane1", {29'b0, impl_lane}, 32'd1);
        checkOutput("bp_valid", {31'b0, impl_valid}, 32'd1);
        applyStimulus(8'h80, 1'b0, 1'b0);
        checkOutput("bp_hold_lane", {29'b0, impl_lane}, 32'd1);
        checkOutput("bp_hold_lit", {16'b0, impl_lit}, 32'h0201);
        checkOutput("bp_hold_cnt", {28'b0, pending_cnt}, 32'd1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("bp_hold2_lane", {29'b0, impl_lane}, 32'd1);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("bp_lane7", {29'b0, impl_lane}, 32'd7);
        checkOutput("bp_lit7", {16'b0, impl_lit}, 32'h0207);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("bp_done_valid", {31'b0, impl_valid}, 32'd0);

        // Flush collision: pend=0F with lane 3 presented, flush plus req on lane 4
        for (int i = 0; i < 8; i++) setLit(i, 16'h0300 + 16'(i));
        applyStimulus(8'h0F, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        applyStimulus(8'h08, 1'b0, 1'b0);
        checkOutput("fl_pre_cnt", {28'b0, pending_cnt}, 32'd4);
        checkOutput("fl_pre_lane", {29'b0, impl_lane}, 32'd3);
        checkOutput("fl_pre_valid", {31'b0, impl_valid}, 32'd1);
        applyStimulus(8'h10, 1'b0, 1'b1);
        checkOutput("fl_valid", {31'b0, impl_valid}, 32'd0);
        checkOutput("fl_cnt", {28'b0, pending_cnt}, 32'd0);
        checkOutput("fl_lane_kept", {29'b0, impl_lane}, 32'd3);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h00, 1'b1, 1'b0);
            checkOutput("fl_no_issue", {31'b0, impl_valid}, 32'd0);
        end
        checkOutput("fl_ovf_clear", {31'b0, overflow}, 32'd0);

        // Overwrite: lane 3 pending with A behind a stalled lane 7, then B arrives
        setLit(7, 16'h0307);
        setLit(3, 16'h00AA);
        applyStimulus(8'h88, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("ow_lane7", {29'b0, impl_lane}, 32'd7);
        setLit(3, 16'h00BB);
        applyStimulus(8'h08, 1'b0, 1'b0);
        checkOutput("ow_ovf", {31'b0, overflow}, {31'b0, exp_ovf});
        checkOutput("ow_cnt", {28'b0, pending_cnt}, 32'd1);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("ow_lane3", {29'b0, impl_lane}, 32'd3);
        checkOutput("ow_litB", {16'b0, impl_lit}, 32'h00BB);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("ow_once_valid", {31'b0, impl_valid}, 32'd0);
        checkOutput("ow_once_idle", {31'b0, idle}, 32'd1);
        checkOutput("ow_ovf_sticky", {31'b0, overflow}, {31'b0, exp_ovf});

        // Asynchronous reset in the middle of activity
        applyStimulus(8'hFF, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_cnt", {28'b0, pending_cnt}, 32'd0);
        checkOutput("mid_rst_ovf", {31'b0, overflow}, 32'd0);
        req_in = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h00, 1'b1, 1'b0);
            checkOutput("mid_rst_quiet", {31'b0, impl_valid}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
